// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit for the EX stage.
//
// A MULT/MULTU/DIV/DIVU operation runs on unsigned magnitudes, one bit per
// cycle. A final cycle applies the sign correction and writes HI/LO. The unit
// also takes MTHI/MTLO writes while it is idle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op         start request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_data, rt_data  operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   hi_we, lo_we      MTHI / MTLO write enables (idle only, start has priority)
//   wdata             MTHI / MTLO write data
//   hi, lo            architectural HI/LO registers
//   busy              operation in progress
//   done              single-cycle pulse when HI/LO take a result
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; accepts start or MTHI/MTLO writes
// RUN   | one shift-add / restoring-divide step per cycle, DATA_W steps
// FIX   | sign correction, divide-by-zero override, HI/LO write, done

module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic                  sign_a_q, sign_a_d;
    logic                  sign_b_q, sign_b_d;
    logic [DATA_W-1:0]     raw_a_q, raw_a_d;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [DATA_W-1:0]     opnd_q, opnd_d;
    // Product shift register (multiply) or remainder:quotient (divide).
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  in_signed;
    logic                  in_neg_a, in_neg_b;
    logic [DATA_W-1:0]     in_mag_a, in_mag_b;

    logic                  is_div, is_signed;
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next;
    logic [DATA_W:0]       div_top;
    logic [DATA_W:0]       div_diff;
    logic                  div_ge;
    logic [2*DATA_W-1:0]   div_next;
    logic [2*DATA_W-1:0]   prod_neg;
    logic [DATA_W-1:0]     quot, rem;

    assign in_signed = ~op[0];
    assign in_neg_a  = in_signed & rs_data[DATA_W-1];
    assign in_neg_b  = in_signed & rt_data[DATA_W-1];
    assign in_mag_a  = in_neg_a ? (~rs_data + 1'b1) : rs_data;
    assign in_mag_b  = in_neg_b ? (~rt_data + 1'b1) : rt_data;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    // Shift-add: conditionally add the multiplicand to the upper half, then
    // shift the whole product right, retiring one multiplier bit.
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    // Restoring divide: the shifted partial remainder needs DATA_W+1 bits
    // because it can reach 2*divisor-1 before the compare.
    assign div_top  = acc_q[2*DATA_W-1:DATA_W-1];
    assign div_diff = div_top - {1'b0, opnd_q};
    assign div_ge   = div_top >= {1'b0, opnd_q};
    assign div_next = div_ge ? {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1}
                             : {acc_q[2*DATA_W-2:0], 1'b0};

    assign prod_neg = ~acc_q + 1'b1;
    assign quot     = acc_q[DATA_W-1:0];
    assign rem      = acc_q[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        raw_a_d  = raw_a_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = in_neg_a;
                    sign_b_d = in_neg_b;
                    raw_a_d  = rs_data;
                    opnd_d   = op[1] ? in_mag_b : in_mag_a;
                    acc_d    = {{DATA_W{1'b0}}, (op[1] ? in_mag_a : in_mag_b)};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end

            RUN: begin
                acc_d = is_div ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = FIX;
            end

            FIX: begin
                if (!is_div) begin
                    {hi_d, lo_d} = (is_signed && (sign_a_q ^ sign_b_q)) ? prod_neg : acc_q;
                end else if (opnd_q == '0) begin
                    hi_d = raw_a_q;
                    lo_d = '1;
                end else begin
                    lo_d = (is_signed && (sign_a_q ^ sign_b_q)) ? (~quot + 1'b1) : quot;
                    hi_d = (is_signed && sign_a_q) ? (~rem + 1'b1) : rem;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            raw_a_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            raw_a_q  <= raw_a_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
